// File: rtl/cnn_counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cnn_counter_pkg
// Description : Shared types and helpers for the nested loop-index generator.
//               Holds the FSM state encoding and the helper that pulls one
//               level's field out of a packed per-level bus.
//               Optional feature macro: COUNTER_STRIDE_EN (used by the
//               counter files, not by this package).
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_counter_pkg;

   // Controller states: idle, emitting tuples, one-cycle completion.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } counter_state_t;

   // Widest packed bus and widest single field the slice helper handles.
   // NUM_LEVELS*BITWIDTH must not exceed MAX_BUS_W, BITWIDTH must not
   // exceed MAX_FIELD_W.
   localparam int MAX_BUS_W   = 1024;
   localparam int MAX_FIELD_W = 32;

   // Return field 'level' of width 'width' from a packed bus, zero-extended.
   function automatic logic [MAX_FIELD_W-1:0] level_slice(
      input logic [MAX_BUS_W-1:0] bus,
      input int unsigned          level,
      input int unsigned          width
   );
      logic [MAX_FIELD_W-1:0] mask;
      if (width >= MAX_FIELD_W)
         mask = '1;
      else
         mask = (MAX_FIELD_W'(1) << width) - MAX_FIELD_W'(1);
      return MAX_FIELD_W'(bus >> (level * width)) & mask;
   endfunction

endpackage : cnn_counter_pkg
`default_nettype wire

// File: rtl/counter_level_stage.sv
`default_nettype none
// ============================================================================
// Module      : counter_level_stage
// Description : Combinational step logic for one loop level. Decides whether
//               the level sits at its terminal value, propagates the carry
//               and produces the index the level takes if it is stepped.
//               Optional feature macro: COUNTER_STRIDE_EN (programmable step).
// Revision    : 1.0 - initial release
// ============================================================================
module counter_level_stage
   import cnn_counter_pkg::*;
#(
   parameter int BITWIDTH = 10
)
(
   input  logic [BITWIDTH-1:0] idx,
   input  logic [BITWIDTH-1:0] limit,
`ifdef COUNTER_STRIDE_EN
   input  logic [BITWIDTH-1:0] stride,
`endif
   input  logic                carry_in,
   output logic                at_limit,
   output logic                carry_out,
   output logic [BITWIDTH-1:0] idx_next
);

   logic [BITWIDTH-1:0] step;
   logic [BITWIDTH:0]   sum;

`ifdef COUNTER_STRIDE_EN
   // Programmable step; a zero stride would stall the level forever, so it
   // behaves as a unit step. The wrap test uses the extra sum bit so an
   // index near the top of the range can never alias back below the limit.
   always_comb begin
      step     = (stride == '0) ? BITWIDTH'(1) : stride;
      sum      = {1'b0, idx} + {1'b0, step};
      at_limit = (sum > {1'b0, limit});
   end
`else
   // Unit step; the carry bit of the sum only rises when idx is all ones,
   // which can only happen with idx == limit, so it never changes the result.
   always_comb begin
      step     = BITWIDTH'(1);
      sum      = {1'b0, idx} + {1'b0, step};
      at_limit = (idx == limit) | sum[BITWIDTH];
   end
`endif

   // Carry ripples outward only through levels sitting at their limit;
   // a stepped level either wraps to zero or takes the incremented value.
   always_comb begin
      carry_out = carry_in & at_limit;
      if (!carry_in)
         idx_next = idx;
      else if (at_limit)
         idx_next = '0;
      else
         idx_next = sum[BITWIDTH-1:0];
   end

endmodule : counter_level_stage
`default_nettype wire

// File: rtl/nested_loop_counter.sv
`default_nettype none
// ============================================================================
// Module      : nested_loop_counter
// Description : Multi-level loop-index generator for the CNN datapath.
//               NUM_LEVELS cascaded counters (level 0 innermost) with
//               programmable terminal values; emits one index tuple per
//               valid/ready handshake and pulses Done after the last one.
//               Optional feature macro: COUNTER_STRIDE_EN adds the
//               COUNTER_Stride port and a per-level programmable step.
// Revision    : 1.0 - initial release
// ============================================================================
module nested_loop_counter
   import cnn_counter_pkg::*;
#(
   parameter int NUM_LEVELS = 3,
   parameter int BITWIDTH   = 10
)
(
   input  logic                           COUNTER_Clk,
   input  logic                           COUNTER_Clr,
   input  logic                           COUNTER_Start,
   input  logic                           COUNTER_Abort,
   input  logic [NUM_LEVELS*BITWIDTH-1:0] COUNTER_Limit,
`ifdef COUNTER_STRIDE_EN
   input  logic [NUM_LEVELS*BITWIDTH-1:0] COUNTER_Stride,
`endif
   input  logic                           COUNTER_Ready,
   output logic                           COUNTER_Valid,
   output logic [NUM_LEVELS*BITWIDTH-1:0] COUNTER_Out,
   output logic [NUM_LEVELS-1:0]          COUNTER_Wrap,
   output logic                           COUNTER_Last,
   output logic                           COUNTER_Done,
   output logic                           COUNTER_Busy
);

   localparam int BUS_W = NUM_LEVELS * BITWIDTH;

   counter_state_t        state;
   counter_state_t        next_state;

   logic [BUS_W-1:0]      limit_q;
`ifdef COUNTER_STRIDE_EN
   logic [BUS_W-1:0]      stride_q;
`endif

   logic [BITWIDTH-1:0]   idx_q    [NUM_LEVELS];
   logic [BITWIDTH-1:0]   idx_next [NUM_LEVELS];
   logic [NUM_LEVELS-1:0] at_limit;
   logic [NUM_LEVELS:0]   carry;

   logic                  valid_q;
   logic                  done_q;
   logic                  valid_next;
   logic                  done_next;

   logic                  advance;
   logic                  all_at_limit;
   logic                  load_cfg;
   logic                  clear_idx;
   logic                  step_idx;

   // Level 0 always receives a carry; the outermost carry-out means every
   // level is at its limit, i.e. the current tuple is the final one.
   assign carry[0]     = 1'b1;
   assign all_at_limit = carry[NUM_LEVELS];
   assign advance      = valid_q & COUNTER_Ready;

   // One step stage per level, chained through the carry vector.
   generate
      for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_level
         logic [BITWIDTH-1:0] lvl_limit;
         assign lvl_limit = BITWIDTH'(level_slice(MAX_BUS_W'(limit_q), i, BITWIDTH));
`ifdef COUNTER_STRIDE_EN
         logic [BITWIDTH-1:0] lvl_stride;
         assign lvl_stride = BITWIDTH'(level_slice(MAX_BUS_W'(stride_q), i, BITWIDTH));
`endif

         counter_level_stage #(
            .BITWIDTH  (BITWIDTH)
         ) u_stage (
            .idx       (idx_q[i]),
            .limit     (lvl_limit),
`ifdef COUNTER_STRIDE_EN
            .stride    (lvl_stride),
`endif
            .carry_in  (carry[i]),
            .at_limit  (at_limit[i]),
            .carry_out (carry[i+1]),
            .idx_next  (idx_next[i])
         );

         assign COUNTER_Out[i*BITWIDTH +: BITWIDTH] = idx_q[i];
      end
   endgenerate

   // Next-state and control decode; Abort overrides every other request.
   always_comb begin
      next_state = state;
      load_cfg   = 1'b0;
      clear_idx  = 1'b0;
      step_idx   = 1'b0;
      if (COUNTER_Abort) begin
         next_state = ST_IDLE;
         clear_idx  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (COUNTER_Start) begin
                  next_state = ST_RUN;
                  load_cfg   = 1'b1;
                  clear_idx  = 1'b1;
               end
            end
            ST_RUN: begin
               if (advance) begin
                  if (all_at_limit) begin
                     next_state = ST_FIN;
                     clear_idx  = 1'b1;
                  end else begin
                     step_idx   = 1'b1;
                  end
               end
            end
            ST_FIN: begin
               next_state = ST_IDLE;
            end
            default: begin
               next_state = ST_IDLE;
               clear_idx  = 1'b1;
            end
         endcase
      end
      valid_next = (next_state == ST_RUN);
      done_next  = (next_state == ST_FIN);
   end

   // State, Valid and Done registers.
   always_ff @(posedge COUNTER_Clk or negedge COUNTER_Clr) begin
      if (!COUNTER_Clr) begin
         state   <= ST_IDLE;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= next_state;
         valid_q <= valid_next;
         done_q  <= done_next;
      end
   end

   // Terminal values (and steps) are captured only when a run is accepted,
   // so later changes on the input buses cannot disturb a run in progress.
   always_ff @(posedge COUNTER_Clk or negedge COUNTER_Clr) begin
      if (!COUNTER_Clr) begin
         limit_q  <= '0;
`ifdef COUNTER_STRIDE_EN
         stride_q <= '0;
`endif
      end else if (load_cfg) begin
         limit_q  <= COUNTER_Limit;
`ifdef COUNTER_STRIDE_EN
         stride_q <= COUNTER_Stride;
`endif
      end
   end

   // Index registers: cleared on start/finish/abort, stepped on handshake,
   // otherwise held so a stalled consumer sees a stable tuple.
   always_ff @(posedge COUNTER_Clk or negedge COUNTER_Clr) begin
      if (!COUNTER_Clr) begin
         for (int i = 0; i < NUM_LEVELS; i++)
            idx_q[i] <= '0;
      end else if (clear_idx) begin
         for (int i = 0; i < NUM_LEVELS; i++)
            idx_q[i] <= '0;
      end else if (step_idx) begin
         for (int i = 0; i < NUM_LEVELS; i++)
            idx_q[i] <= idx_next[i];
      end
   end

   assign COUNTER_Valid = valid_q;
   assign COUNTER_Done  = done_q;
   assign COUNTER_Busy  = (state != ST_IDLE);
   assign COUNTER_Last  = valid_q & all_at_limit;
   assign COUNTER_Wrap  = {NUM_LEVELS{advance}} & carry[NUM_LEVELS:1];

endmodule : nested_loop_counter
`default_nettype wire
